// File: rtl/mct_pkg.sv
// Shared types and default sizes for the multi-controlled-Toffoli sequencer family.
package mct_pkg;

  localparam int unsigned MctNBits = 8;
  localparam int unsigned MctDepth = 16;
  localparam int unsigned MctTw    = $clog2(MctNBits);

  typedef struct packed {
    logic                en;
    logic [MctNBits-1:0] ctrl;
    logic [MctTw-1:0]    tgt;
  } gate_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

endpackage

// File: rtl/mct_gate_apply.sv
// Combinational application of one MCT gate to a classical register.
module mct_gate_apply
  import mct_pkg::*;
#(
  parameter int unsigned N_BITS = MctNBits,
  parameter int unsigned TW     = $clog2(N_BITS),
  parameter type         gate_t = mct_pkg::gate_t
) (
  input  logic [N_BITS-1:0] bits_in,
  input  gate_t             gate,
  output logic [N_BITS-1:0] bits_out,
  output logic              illegal
);

  logic tgt_ok;

  always_comb begin
    bits_out = bits_in;
    illegal  = 1'b0;
    tgt_ok   = 32'(gate.tgt) < N_BITS;
    if (gate.en) begin
      // A target outside the register, or one that is also a control, makes the gate a NOP.
      if (!tgt_ok) begin
        illegal = 1'b1;
      end else if (gate.ctrl[gate.tgt]) begin
        illegal = 1'b1;
      end else if ((bits_in & gate.ctrl) == gate.ctrl) begin
        bits_out[gate.tgt] = ~bits_in[gate.tgt];
      end
    end
  end

endmodule

// File: rtl/mct_sequencer.sv
// Runs a programmable list of MCT gates over an N_BITS register, forward or in reverse.
module mct_sequencer
  import mct_pkg::*;
#(
  parameter int unsigned N_BITS = MctNBits,
  parameter int unsigned DEPTH  = MctDepth,
  parameter int unsigned TW     = $clog2(N_BITS),
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic              prog_en,
  input  logic [N_BITS-1:0] prog_ctrl,
  input  logic [TW-1:0]     prog_tgt,
  input  logic [AW:0]       prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  input  logic              in_reverse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned LenW = AW + 1;

  typedef struct packed {
    logic              en;
    logic [N_BITS-1:0] ctrl;
    logic [TW-1:0]     tgt;
  } slot_t;

  logic [DEPTH-1:0]  en_q;
  logic [N_BITS-1:0] ctrl_q [DEPTH];
  logic [TW-1:0]     tgt_q  [DEPTH];

  state_t            state_q;
  logic [N_BITS-1:0] reg_q;
  logic [AW-1:0]     ptr_q;
  logic [LenW-1:0]   cnt_q;
  logic              rev_q;
  logic              err_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              in_ready_q;

  logic [LenW-1:0]   len_sat;
  slot_t             cur_gate;
  logic [N_BITS-1:0] reg_next;
  logic              gate_illegal;

  assign len_sat = (prog_len > LenW'(DEPTH)) ? LenW'(DEPTH) : prog_len;

  assign cur_gate.en   = en_q[ptr_q];
  assign cur_gate.ctrl = ctrl_q[ptr_q];
  assign cur_gate.tgt  = tgt_q[ptr_q];

  mct_gate_apply #(
    .N_BITS (N_BITS),
    .TW     (TW),
    .gate_t (slot_t)
  ) u_gate_apply (
    .bits_in  (reg_q),
    .gate     (cur_gate),
    .bits_out (reg_next),
    .illegal  (gate_illegal)
  );

  // Slot payload carries no reset; a cleared enable bit already makes the slot a NOP.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == StIdle)) begin
      ctrl_q[prog_addr] <= prog_ctrl;
      tgt_q[prog_addr]  <= prog_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      en_q        <= '0;
      reg_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rev_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (prog_we) en_q[prog_addr] <= prog_en;
          if (in_valid) begin
            reg_q      <= in_data;
            err_q      <= 1'b0;
            rev_q      <= in_reverse;
            cnt_q      <= len_sat;
            ptr_q      <= in_reverse ? AW'(len_sat - LenW'(1)) : '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if (len_sat == '0) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          reg_q <= reg_next;
          if (gate_illegal) err_q <= 1'b1;
          cnt_q <= cnt_q - LenW'(1);
          if (cnt_q == LenW'(1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            ptr_q <= rev_q ? ptr_q - AW'(1) : ptr_q + AW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = reg_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mct_sequencer.sv
// Self-checking bench for mct_sequencer: directed table, corner sequences, random vs model.
module tb_mct_sequencer;

  localparam int N  = 8;
  localparam int D  = 16;
  localparam int TW = 3;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic          prog_en;
  logic [N-1:0]  prog_ctrl;
  logic [TW-1:0] prog_tgt;
  logic [AW:0]   prog_len;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_reverse;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          busy;
  logic          err;

  mct_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_en    (prog_en),
    .prog_ctrl  (prog_ctrl),
    .prog_tgt   (prog_tgt),
    .prog_len   (prog_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_reverse (in_reverse),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference program memory, mirrored from the host writes.
  bit       m_en   [D];
  bit [7:0] m_ctrl [D];
  int       m_tgt  [D];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_run(input bit [7:0] din, input bit rev, input int len,
                                    output bit [7:0] dout, output bit e);
    int n = (len > D) ? D : len;
    dout = din;
    e = 1'b0;
    for (int k = 0; k < n; k++) begin
      int s = rev ? (n - 1 - k) : k;
      if (m_en[s]) begin
        if (m_tgt[s] >= N || m_ctrl[s][m_tgt[s]]) e = 1'b1;
        else if ((dout & m_ctrl[s]) == m_ctrl[s]) dout ^= 8'(1 << m_tgt[s]);
      end
    end
  endfunction

  task automatic prog(input int addr, input bit en, input bit [7:0] ctrl, input int tgt);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = AW'(addr); prog_en = en; prog_ctrl = ctrl; prog_tgt = TW'(tgt);
    @(negedge clk);
    prog_we = 1'b0;
    m_en[addr] = en; m_ctrl[addr] = ctrl; m_tgt[addr] = tgt;
  endtask

  // One complete transaction; hold > 0 keeps out_ready low and pokes in_valid/prog_we meanwhile.
  task automatic run(input string name, input bit [7:0] din, input bit rev, input int len,
                     input int hold, input bit [7:0] exp_out, input bit exp_err);
    int lat;
    int exp_lat = (len > D) ? D : len;
    @(negedge clk);
    chk({name, ".in_ready"}, 32'(in_ready), 1);
    in_data = din; in_reverse = rev; prog_len = 5'(len); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom); in_reverse = 1'($urandom);
    chk({name, ".err_clr"}, 32'(err), 0);
    chk({name, ".busy"}, 32'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({name, ".out"}, 32'(out_data), 32'(exp_out));
    chk({name, ".err"}, 32'(err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = ~din;
      prog_we = 1'b1; prog_addr = '0; prog_en = 1'b0; prog_ctrl = 8'hFF; prog_tgt = '0;
      @(negedge clk);
      chk({name, ".hold_valid"}, 32'(out_valid), 1);
      chk({name, ".hold_data"}, 32'(out_data), 32'(exp_out));
      chk({name, ".hold_ready"}, 32'(in_ready), 0);
    end
    in_valid = 1'b0; prog_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ".drain_valid"}, 32'(out_valid), 0);
    chk({name, ".drain_ready"}, 32'(in_ready), 1);
    chk({name, ".drain_busy"}, 32'(busy), 0);
  endtask

  typedef struct {
    bit [7:0] ctrl;
    int       tgt;
    int       len;
    bit [7:0] din;
    bit       rev;
    bit [7:0] dout;
    bit       eflag;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit [7:0] r, rr;
    bit       e, ee;
    int       len;
    bit       rev;
    bit [7:0] din;

    tbl[0] = '{8'h03, 2, 1, 8'h03, 1'b0, 8'h07, 1'b0};
    tbl[1] = '{8'h03, 2, 1, 8'h07, 1'b0, 8'h03, 1'b0};
    tbl[2] = '{8'h03, 2, 1, 8'h01, 1'b0, 8'h01, 1'b0};
    tbl[3] = '{8'h04, 2, 1, 8'h04, 1'b0, 8'h04, 1'b1};
    tbl[4] = '{8'h03, 2, 1, 8'h03, 1'b1, 8'h07, 1'b0};
    tbl[5] = '{8'h00, 7, 1, 8'h00, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{8'h81, 3, 1, 8'h81, 1'b0, 8'h89, 1'b0};
    tbl[7] = '{8'h81, 3, 1, 8'h80, 1'b0, 8'h80, 1'b0};
    tbl[8] = '{8'h03, 2, 0, 8'hA5, 1'b0, 8'hA5, 1'b0};
    tbl[9] = '{8'h02, 1, 1, 8'h00, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_en = 1'b0; prog_ctrl = '0;
    prog_tgt = '0; prog_len = '0; in_valid = 1'b0; in_data = '0; in_reverse = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) begin m_en[i] = 0; m_ctrl[i] = 0; m_tgt[i] = 0; end
    #12;
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.in_ready", 32'(in_ready), 1);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.out_data", 32'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a run.
    for (int i = 0; i < 4; i++) prog(i, 1'b1, 8'h00, 0);
    prog(4, 1'b1, 8'h04, 2);
    @(negedge clk);
    in_data = 8'h11; in_reverse = 1'b0; prog_len = 5'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.err", 32'(err), 0);
    chk("midrst.in_ready", 32'(in_ready), 1);
    chk("midrst.out_data", 32'(out_data), 0);
    for (int i = 0; i < D; i++) m_en[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run("after_reset", 8'h5A, 1'b0, 2, 0, 8'h5A, 1'b0);

    // Directed single-slot table.
    foreach (tbl[i]) begin
      prog(0, 1'b1, tbl[i].ctrl, tbl[i].tgt);
      run($sformatf("tbl%0d", i), tbl[i].din, tbl[i].rev, tbl[i].len, 0, tbl[i].dout,
          tbl[i].eflag);
    end

    // NOT b0; CNOT b0->b1; CCNOT b0,b1->b7.
    prog(0, 1'b1, 8'h00, 0);
    prog(1, 1'b1, 8'h01, 1);
    prog(2, 1'b1, 8'h03, 7);
    run("three_fwd", 8'h00, 1'b0, 3, 0, 8'h83, 1'b0);
    run("three_rev", 8'h83, 1'b1, 3, 0, 8'h00, 1'b0);

    // Backpressure: writes to slot 0 during DONE must not land.
    run("backpressure", 8'h00, 1'b0, 3, 5, 8'h83, 1'b0);
    run("readback", 8'h00, 1'b0, 3, 0, 8'h83, 1'b0);

    // Saturating length: 16 NOTs on b0 leave the word unchanged.
    for (int i = 0; i < D; i++) prog(i, 1'b1, 8'h00, 0);
    run("len_sat", 8'h3C, 1'b0, D + 5, 0, 8'h3C, 1'b0);
    run("len_15", 8'h3C, 1'b0, 15, 0, 8'h3D, 1'b0);

    // Random programs against the model, then reverse to check reversibility.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < D; i++)
        prog(i, 1'($urandom_range(0, 3) != 0), 8'($urandom & $urandom & $urandom),
             $urandom_range(0, N - 1));
      len = $urandom_range(0, 31);
      rev = 1'($urandom);
      din = 8'($urandom);
      model_run(din, rev, len, r, e);
      run($sformatf("rnd%0d", t), din, rev, len, 0, r, e);
      model_run(r, ~rev, len, rr, ee);
      chk($sformatf("rnd%0d.model_inv", t), 32'(rr), 32'(din));
      run($sformatf("rnd%0d_inv", t), r, ~rev, len, 0, din, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
